ps2_scancode_rx: RTL and testbench
==================================

Name: ps2_scancode_rx

Overview:
Receives the PS/2 keyboard serial stream (ps2_clk/ps2_data pads) and delivers decoded scan codes to Dispatch through a small show-ahead FIFO. It synchronises and filters the pad signals and frames the 11-bit device-to-host packets. It folds the E0 (extended) and F0 (break) prefix bytes into per-code flags. It sits directly upstream of Dispatch, replacing raw pad handling there.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised ps2_clk samples required to change the filtered clock level
TIMEOUT_CYCLES, 50000, clk cycles without a filtered falling edge mid-frame before the frame is aborted (1 ms at 50 MHz)
FIFO_DEPTH, 4, scan-code FIFO entries (power of 2)

Ports:
clk  input  1  system clock, the BUFG output
reset  input  1  synchronous, active-high
ps2_clk  input  1  raw keyboard clock pad, asynchronous
ps2_data  input  1  raw keyboard data pad, asynchronous
rd_en  input  1  pops the FIFO head; ignored when code_valid=0
code_valid  output  1  FIFO not empty
code_out  output  8  scan code at the FIFO head
code_ext  output  1  head code was preceded by E0
code_break  output  1  head code was preceded by F0
fifo_full  output  1  FIFO holds FIFO_DEPTH entries
frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error
overflow  output  1  one-cycle pulse when a completed code is dropped because the FIFO is full

Behaviour:
- Reset values: code_valid=0, code_out=0, code_ext=0, code_break=0, fifo_full=0, frame_err=0, overflow=0. Reset also empties the FIFO, clears both prefix flags, forces state IDLE and presets the filtered clock to 1. Reset mid-frame discards the partial frame.
- Synchronisation: two-flop synchroniser on each pad.
- Clock filter: a counter tracks consecutive synchronised ps2_clk samples that differ from the filtered level. On reaching FILTER_LEN the filtered level toggles. Any sample equal to the filtered level clears the counter.
- Edge detection: a filtered 1->0 transition produces a one-cycle fall strobe. Synchronised ps2_data is sampled in that same cycle.
- FSM states:
  - IDLE: fall with data=0 -> SHIFT, bit count=0, timeout cleared. Fall with data=1 -> pulse frame_err, stay in IDLE.
  - SHIFT: each fall shifts data into bit[count], LSB first. After the 8th bit -> PARITY.
  - PARITY: fall captures the parity bit -> STOP.
  - STOP: fall samples the stop bit -> CHECK.
  - CHECK (one cycle): the frame is good when stop=1 and (XOR of the 8 data bits XOR parity)=1, i.e. odd parity. Good -> byte handling. Bad -> frame_err pulse and both prefix flags cleared. Either way return to IDLE.
- Timeout: in SHIFT, PARITY or STOP, the timeout counter increments each cycle and clears on each fall. On reaching TIMEOUT_CYCLES: frame_err pulse, prefix flags cleared, -> IDLE.
- Byte handling for a good frame:
  - 0xE0: set ext_pending; no push.
  - 0xF0: set brk_pending; no push.
  - Any other byte: push {ext_pending, brk_pending, byte} and clear both pending flags.
- FIFO:
  - Show-ahead: code_out, code_ext and code_break reflect the head entry whenever code_valid=1.
  - A push becomes visible the cycle after CHECK. Total latency is stop-bit fall -> code_valid high = 2 cycles when the FIFO was empty.
  - A pop (rd_en & code_valid) advances the head on the next edge.
  - Push while full and not popping: the entry is dropped, overflow pulses, pending flags are cleared.
  - Push and pop in the same cycle when full: both occur, occupancy is unchanged, no overflow.
  - Push and pop in the same cycle when empty: the push is kept, the pop is ignored.
  - Read and write pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. Occupancy is tracked with a counter 0..FIFO_DEPTH.
- code_out and the flags hold their last values while the FIFO is empty. Consumers qualify them with code_valid.

Test Plan:
- Send frame for 0x1C (start 0, data LSB first, parity 0, stop 1), rd_en=0 -> code_valid rises 2 cycles after the stop fall; code_out=0x1C, ext=0, break=0.
- Send 0xE0, 0xF0, 0x75 -> exactly one entry: code_out=0x75, ext=1, break=1. Then send 0x75 -> second entry with ext=0, break=0.
- Send 0x1C with parity=1 -> frame_err pulses once, FIFO stays empty; a following good 0x32 is received correctly.
- Stop after 4 data bits with ps2_clk idle high for TIMEOUT_CYCLES -> frame_err pulses, FSM in IDLE; the next full frame 0x1C is received.
- Push 5 codes 0x01..0x05 with rd_en=0 -> fifo_full after the 4th, overflow pulses on the 5th, pops return 0x01..0x04. Repeat with rd_en asserted in the 5th push cycle -> no overflow, 0x05 retained.
- Inject 3-cycle glitches on ps2_clk (shorter than FILTER_LEN) during a frame; assert reset mid-frame -> glitches produce no bit shifts; after reset all outputs are 0 and the next frame 0x29 decodes cleanly.

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: syncs and glitch-filters the pads, frames 11-bit packets, folds E0/F0 prefixes into flags.
// Latency: the filtered ps2_clk fall that samples the stop bit leads code_valid by 2 clk cycles when the FIFO is empty.
// Backpressure: a show-ahead FIFO absorbs codes; a code that arrives when the FIFO is full (and no pop) is dropped with an overflow pulse.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   ps2_clk, ps2_data   raw asynchronous keyboard pads
//   rd_en               pops the FIFO head (ignored while code_valid=0)
//   code_valid          FIFO not empty; code_out/code_ext/code_break show the head entry
//   fifo_full           FIFO holds FIFO_DEPTH entries
//   frame_err           one-cycle pulse on start/parity/stop/timeout error
//   overflow            one-cycle pulse when a completed code is dropped
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic       code_valid,
    output logic [7:0] code_out,
    output logic       code_ext,
    output logic       code_break,
    output logic       fifo_full,
    output logic       frame_err,
    output logic       overflow
);

    localparam int FCW  = $clog2(FILTER_LEN + 1);
    localparam int TCW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    localparam logic [FCW-1:0]  FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0]  TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_PARITY,
        S_STOP,
        S_CHECK
    } state_t;

    // ------------------------------------------------------------------
    // Pad synchroniser and ps2_clk glitch filter
    // ------------------------------------------------------------------
    logic           clk_s1_q, clk_s2_q;
    logic           dat_s1_q, dat_s2_q;
    logic           filt_clk_q, filt_prev_q;
    logic [FCW-1:0] filt_cnt_q;
    logic           fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Pads idle high; presetting the chain to 1 avoids a false fall after reset.
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_clk_q  <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2_data;
            dat_s2_q    <= dat_s1_q;
            filt_prev_q <= filt_clk_q;
            // The filtered level only moves after FILTER_LEN consecutive disagreeing samples.
            if (clk_s2_q != filt_clk_q) begin
                if (filt_cnt_q == FILT_LAST) begin
                    filt_clk_q <= ~filt_clk_q;
                    filt_cnt_q <= '0;
                end else begin
                    filt_cnt_q <= filt_cnt_q + FCW'(1);
                end
            end else begin
                filt_cnt_q <= '0;
            end
        end
    end

    assign fall = filt_prev_q & ~filt_clk_q;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic           stop_q, stop_d;
    logic [TCW-1:0] to_cnt_q, to_cnt_d;
    logic           ext_pend_q, ext_pend_d;
    logic           brk_pend_q, brk_pend_d;
    logic           frame_err_q, frame_err_d;
    logic           overflow_q, overflow_d;
    logic           push_req;
    logic           frame_good;

    // Odd parity over data+parity, and a high stop bit.
    assign frame_good = stop_q & (^{shift_q, par_q});

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        stop_d      = stop_q;
        to_cnt_d    = to_cnt_q;
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        frame_err_d = 1'b0;
        push_req    = 1'b0;

        case (state_q)
            S_IDLE: begin
                to_cnt_d = '0;
                if (fall) begin
                    if (!dat_s2_q) begin
                        state_d   = S_SHIFT;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;   // start bit must be 0
                    end
                end
            end
            S_SHIFT, S_PARITY, S_STOP: begin
                if (fall) begin
                    to_cnt_d = '0;
                    if (state_q == S_SHIFT) begin
                        // LSB arrives first: shift in from the top.
                        shift_d   = {dat_s2_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_PARITY;
                        end
                    end else if (state_q == S_PARITY) begin
                        par_d   = dat_s2_q;
                        state_d = S_STOP;
                    end else begin
                        stop_d  = dat_s2_q;
                        state_d = S_CHECK;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    frame_err_d = 1'b1;
                    ext_pend_d  = 1'b0;
                    brk_pend_d  = 1'b0;
                    to_cnt_d    = '0;
                    state_d     = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TCW'(1);
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (frame_good) begin
                    if (shift_q == 8'hE0) begin
                        ext_pend_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        brk_pend_d = 1'b1;
                    end else begin
                        // Prefixes are consumed whether or not the FIFO accepts the code.
                        push_req   = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    ext_pend_d  = 1'b0;
                    brk_pend_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO: entry = {ext, break, code}
    // ------------------------------------------------------------------
    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [CNTW-1:0] count_q, count_d;
    logic [9:0]      head_q, head_d;
    logic [9:0]      push_entry;
    logic            do_push, do_pop;

    assign push_entry = {ext_pend_q, brk_pend_q, shift_q};
    assign rd_ptr_nxt = rd_ptr_q + PW'(1);

    always_comb begin
        // A pop on an empty FIFO is ignored; a push on a full FIFO only lands if a pop frees a slot.
        do_pop     = rd_en & (count_q != '0);
        do_push    = push_req & ((count_q != DEPTH_C) | do_pop);
        overflow_d = push_req & ~do_push;

        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNTW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNTW'(1);
        end

        // The head register holds its value when the FIFO drains, so the outputs keep their last code.
        head_d = head_q;
        if (do_push && (count_q == '0 || (do_pop && count_q == CNTW'(1)))) begin
            head_d = push_entry;
        end else if (do_pop && count_q > CNTW'(1)) begin
            head_d = mem_q[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            stop_q      <= 1'b0;
            to_cnt_q    <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            stop_q      <= stop_d;
            to_cnt_q    <= to_cnt_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            count_q     <= count_d;
            head_q      <= head_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
        end
    end

    assign code_valid = (count_q != '0);
    assign code_ext   = head_q[9];
    assign code_break = head_q[8];
    assign code_out   = head_q[7:0];
    assign fifo_full  = (count_q == DEPTH_C);
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;

    localparam int FILT  = 8;
    localparam int TO    = 400;
    localparam int DEPTH = 4;
    localparam int HALF  = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       code_valid;
    logic [7:0] code_out;
    logic       code_ext, code_break, fifo_full, frame_err, overflow;

    ps2_scancode_rx #(
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TO),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .code_valid(code_valid),
        .code_out  (code_out),
        .code_ext  (code_ext),
        .code_break(code_break),
        .fifo_full (fifo_full),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;
    int exp_ovf = 0;
    logic [9:0] sb[$];
    bit ext_m = 1'b0;
    bit brk_m = 1'b0;

    always @(negedge clk) begin
        if (frame_err) err_cnt++;
        if (overflow)  ovf_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // One PS/2 bit: data set while clock high, then a low phase. Optional 3-cycle glitches in each phase.
    task automatic drive_bit(input logic b, input bit glitch);
        @(posedge clk); #1 ps2_data = b;
        if (glitch) begin
            repeat (11) @(posedge clk); #1 ps2_clk = 1'b0;
            repeat (3) @(posedge clk);  #1 ps2_clk = 1'b1;
            repeat (HALF - 14) @(posedge clk);
        end else begin
            repeat (HALF) @(posedge clk);
        end
        #1 ps2_clk = 1'b0;
        if (glitch) begin
            repeat (12) @(posedge clk); #1 ps2_clk = 1'b1;
            repeat (3) @(posedge clk);  #1 ps2_clk = 1'b0;
            repeat (HALF - 15) @(posedge clk);
        end else begin
            repeat (HALF) @(posedge clk);
        end
        #1 ps2_clk = 1'b1;
    endtask

    // Full frame. chk_lat checks code_valid timing after the stop fall; pop_chk pops the head during CHECK.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit chk_lat,
                              input bit pop_chk, input bit glitch);
        logic [9:0] exp;
        logic [9:0] got;
        drive_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) drive_bit(b[i], glitch);
        drive_bit((~^b) ^ bad_par, glitch);
        @(posedge clk); #1 ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        // 2 sync + FILTER_LEN filter cycles to the fall strobe, then 2 cycles to code_valid.
        for (int i = 1; i <= HALF; i++) begin
            @(negedge clk);
            if (chk_lat && i == 12) begin
                n_cmp++;
                if (code_valid !== 1'b0) begin
                    n_mis++; $display("FAIL latency_early code_valid got %b exp 0", code_valid);
                end
            end
            if (chk_lat && i == 13) begin
                n_cmp++;
                if (code_valid !== 1'b1) begin
                    n_mis++; $display("FAIL latency_edge code_valid got %b exp 1", code_valid);
                end
            end
            if (pop_chk && i == 12) begin
                exp = sb.pop_front();
                got = {code_ext, code_break, code_out};
                n_cmp++;
                if (code_valid !== 1'b1 || got !== exp) begin
                    n_mis++; $display("FAIL pop_in_check got vld=%b %h exp %h", code_valid, got, exp);
                end
                rd_en = 1'b1;
            end
            if (pop_chk && i == 13) rd_en = 1'b0;
        end
        @(posedge clk); #1 ps2_clk = 1'b1;
        repeat (HALF) @(posedge clk);
        if (bad_par) begin
            ext_m = 1'b0; brk_m = 1'b0;
        end else if (b == 8'hE0) begin
            ext_m = 1'b1;
        end else if (b == 8'hF0) begin
            brk_m = 1'b1;
        end else begin
            if (sb.size() < DEPTH) sb.push_back({ext_m, brk_m, b});
            else exp_ovf++;
            ext_m = 1'b0; brk_m = 1'b0;
        end
    endtask

    task automatic read_head(output bit vld, output logic [9:0] got);
        @(negedge clk);
        vld = code_valid;
        got = {code_ext, code_break, code_out};
        if (vld) rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp += 7;
        if (code_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid got %b exp 0", code_valid); end
        if (code_out !== 8'h00)  begin n_mis++; $display("FAIL reset_code got %h exp 00", code_out); end
        if (code_ext !== 1'b0)   begin n_mis++; $display("FAIL reset_ext got %b exp 0", code_ext); end
        if (code_break !== 1'b0) begin n_mis++; $display("FAIL reset_break got %b exp 0", code_break); end
        if (fifo_full !== 1'b0)  begin n_mis++; $display("FAIL reset_full got %b exp 0", fifo_full); end
        if (frame_err !== 1'b0)  begin n_mis++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
        if (overflow !== 1'b0)   begin n_mis++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        @(posedge clk); #1 reset = 1'b0;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_single_latency();
        bit v; logic [9:0] g; logic [9:0] e;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_head(v, g);
            n_cmp++;
            if (v !== 1'b1 || g !== e) begin n_mis++; $display("FAIL single got vld=%b %h exp %h", v, g, e); end
        end
        @(negedge clk); n_cmp++;
        if (code_valid !== 1'b0) begin n_mis++; $display("FAIL single_empty got %b exp 0", code_valid); end
    endtask

    task automatic test_prefix();
        bit v; logic [9:0] g; logic [9:0] e;
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        read_head(v, g);
        n_cmp++;
        if (v !== 1'b1 || g !== e) begin n_mis++; $display("FAIL prefix_head got vld=%b %h exp %h", v, g, e); end
        @(negedge clk); n_cmp++;
        if (code_valid !== 1'b0) begin n_mis++; $display("FAIL prefix_one_entry got vld %b exp 0", code_valid); end
        send_frame(8'h75, 1'b0, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        read_head(v, g);
        n_cmp++;
        if (v !== 1'b1 || g !== e) begin n_mis++; $display("FAIL prefix_plain got vld=%b %h exp %h", v, g, e); end
    endtask

    task automatic test_parity_err();
        bit v; logic [9:0] g; logic [9:0] e;
        int e0;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp += 2;
        if (err_cnt - e0 !== 1) begin n_mis++; $display("FAIL parity_err_pulses got %0d exp 1", err_cnt - e0); end
        if (code_valid !== 1'b0) begin n_mis++; $display("FAIL parity_fifo_empty got %b exp 0", code_valid); end
        send_frame(8'h32, 1'b0, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        read_head(v, g);
        n_cmp++;
        if (v !== 1'b1 || g !== e) begin n_mis++; $display("FAIL parity_recover got vld=%b %h exp %h", v, g, e); end
    endtask

    task automatic test_timeout();
        bit v; logic [9:0] g; logic [9:0] e;
        int e0;
        logic [7:0] b;
        b = 8'h1C;
        e0 = err_cnt;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i], 1'b0);
        repeat (TO + 50) @(posedge clk);
        ext_m = 1'b0; brk_m = 1'b0;
        n_cmp += 2;
        if (err_cnt - e0 !== 1) begin n_mis++; $display("FAIL timeout_err got %0d exp 1", err_cnt - e0); end
        if (code_valid !== 1'b0) begin n_mis++; $display("FAIL timeout_empty got %b exp 0", code_valid); end
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        read_head(v, g);
        n_cmp += 2;
        if (v !== 1'b1 || g !== e) begin n_mis++; $display("FAIL timeout_recover got vld=%b %h exp %h", v, g, e); end
        if (err_cnt - e0 !== 1) begin n_mis++; $display("FAIL timeout_extra_err got %0d exp 1", err_cnt - e0); end
    endtask

    task automatic test_overflow();
        bit v; logic [9:0] g; logic [9:0] e;
        int o0, x0;
        for (int pass = 0; pass < 2; pass++) begin
            o0 = ovf_cnt; x0 = exp_ovf;
            for (int k = 1; k <= 5; k++) begin
                send_frame(8'(k), 1'b0, 1'b0, (pass == 1 && k == 5), 1'b0);
                if (k == 4) begin
                    @(negedge clk); n_cmp++;
                    if (fifo_full !== 1'b1) begin n_mis++; $display("FAIL full_after4 p%0d got %b exp 1", pass, fifo_full); end
                end
            end
            @(negedge clk); n_cmp += 2;
            if (ovf_cnt - o0 !== exp_ovf - x0) begin
                n_mis++; $display("FAIL overflow_pulses p%0d got %0d exp %0d", pass, ovf_cnt - o0, exp_ovf - x0);
            end
            if (fifo_full !== 1'b1) begin n_mis++; $display("FAIL full_after5 p%0d got %b exp 1", pass, fifo_full); end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                read_head(v, g);
                n_cmp++;
                if (v !== 1'b1 || g !== e) begin n_mis++; $display("FAIL ovf_drain p%0d got vld=%b %h exp %h", pass, v, g, e); end
            end
            @(negedge clk); n_cmp++;
            if (code_valid !== 1'b0) begin n_mis++; $display("FAIL ovf_empty p%0d got %b exp 0", pass, code_valid); end
        end
    endtask

    task automatic test_glitch_reset();
        bit v; logic [9:0] g; logic [9:0] e;
        int e0;
        send_frame(8'h29, 1'b0, 1'b0, 1'b0, 1'b1);
        e = sb.pop_front();
        read_head(v, g);
        n_cmp++;
        if (v !== 1'b1 || g !== e) begin n_mis++; $display("FAIL glitch_frame got vld=%b %h exp %h", v, g, e); end
        // Leave a code in the FIFO and an E0 pending, then reset in the middle of a glitchy frame.
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b1);
        @(posedge clk); #1 ps2_data = 1'b0; ps2_clk = 1'b0;
        repeat (15) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp += 8;
        if (code_valid !== 1'b0) begin n_mis++; $display("FAIL rst_valid got %b exp 0", code_valid); end
        if (code_out !== 8'h00)  begin n_mis++; $display("FAIL rst_code got %h exp 00", code_out); end
        if (code_ext !== 1'b0)   begin n_mis++; $display("FAIL rst_ext got %b exp 0", code_ext); end
        if (code_break !== 1'b0) begin n_mis++; $display("FAIL rst_break got %b exp 0", code_break); end
        if (fifo_full !== 1'b0)  begin n_mis++; $display("FAIL rst_full got %b exp 0", fifo_full); end
        if (frame_err !== 1'b0)  begin n_mis++; $display("FAIL rst_ferr got %b exp 0", frame_err); end
        if (overflow !== 1'b0)   begin n_mis++; $display("FAIL rst_ovf got %b exp 0", overflow); end
        if (err_cnt - e0 !== 0)  begin n_mis++; $display("FAIL rst_no_err got %0d exp 0", err_cnt - e0); end
        sb.delete();
        ext_m = 1'b0; brk_m = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        repeat (30) @(posedge clk);
        send_frame(8'h29, 1'b0, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        read_head(v, g);
        n_cmp++;
        if (v !== 1'b1 || g !== e) begin n_mis++; $display("FAIL post_reset got vld=%b %h exp %h", v, g, e); end
        @(negedge clk); n_cmp++;
        if (code_valid !== 1'b0) begin n_mis++; $display("FAIL post_reset_empty got %b exp 0", code_valid); end
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_prefix();
        test_parity_err();
        test_timeout();
        test_overflow();
        test_glitch_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
